weight_fetch_ctrl: RTL and testbench
====================================

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 28, SHALL set the number of weight words per neuron BRAM.
REQ-002 Parameter AW, default 5, SHALL set the BRAM address width.
REQ-003 Parameter DW, default 16, SHALL set the weight word width.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-006 START  in  1  SHALL request one full weight fetch pass (pulse, sampled in IDLE).
REQ-007 LD_START  in  1  SHALL request one full weight load pass (pulse, sampled in IDLE).
REQ-008 LD_DI  in  DW  SHALL carry the load word; LD_VALID in 1 and LD_READY out 1 SHALL form its handshake.
REQ-009 BRAM_ADDR out AW, BRAM_DI out DW, BRAM_EN out 1, BRAM_WE out 1 SHALL drive the weight BRAM port.
REQ-010 BRAM_DO  in  DW  SHALL be the BRAM read data, updated by the BRAM on negedge when EN=1 and WE=0, held otherwise.
REQ-011 W_DATA out DW, W_IDX out AW, W_VALID out 1, W_LAST out 1 and W_READY in 1 SHALL form the weight stream to the MAC.
REQ-012 BUSY out 1 SHALL be high in any state other than IDLE; DONE out 1 and LD_DONE out 1 SHALL be single-cycle completion pulses.

Function
REQ-013 States SHALL be IDLE, LOAD, FETCH, DRAIN; one-hot-free binary encoding.
REQ-014 IDLE: LD_START=1 -> LOAD; else START=1 -> FETCH; both high same cycle -> LOAD wins, START dropped.
REQ-015 START/LD_START outside IDLE SHALL be ignored (no queuing).
REQ-016 On entry to LOAD or FETCH the index counter SHALL be 0.
REQ-017 LOAD: LD_READY=1; each cycle with LD_VALID=1 -> BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=counter, BRAM_DI=LD_DI, counter+1.
REQ-018 LOAD: write at counter=DEPTH-1 -> IDLE next cycle, LD_DONE=1 for that one cycle.
REQ-019 FETCH: issue = (counter<=DEPTH-1) and (W_VALID=0 or W_READY=1); issue -> BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=counter, counter+1.
REQ-020 BRAM control outputs SHALL be combinational from registered state/counter and the handshake inputs; BRAM_EN=0, BRAM_WE=0 whenever no issue/write.
REQ-021 Read latency SHALL be 1 cycle: issue in cycle k -> W_VALID=1 in cycle k+1 with W_DATA=BRAM_DO and W_IDX=issued address.
REQ-022 W_DATA SHALL be driven directly from BRAM_DO; stall (W_VALID=1, W_READY=0) SHALL block issue so BRAM_DO holds.
REQ-023 W_VALID SHALL clear after a transfer (W_VALID&W_READY) with no new issue in the same cycle.
REQ-024 W_LAST SHALL equal W_VALID and (W_IDX=DEPTH-1).
REQ-025 FETCH: issue at counter=DEPTH-1 -> DRAIN; DRAIN: transfer of last word -> IDLE, DONE=1 for one cycle.
REQ-026 Counter SHALL never exceed DEPTH-1 as an address; no wrap-around issue beyond DEPTH-1.
REQ-027 Back-to-back W_READY=1 SHALL yield DEPTH transfers in DEPTH+1 cycles from START.

Reset
REQ-028 RST=1 SHALL force IDLE, counter=0, W_VALID=0, W_IDX=0, DONE=0, LD_DONE=0, LD_READY=0, BUSY=0, BRAM_EN=0, BRAM_WE=0.
REQ-029 RST mid-LOAD or mid-FETCH SHALL abort the pass without a DONE/LD_DONE pulse; partial BRAM contents are left as written.

Structure
REQ-030 Shared package SHALL hold the state encoding and default DEPTH/AW/DW constants for all weight BRAM controllers.
REQ-031 The block SHALL be one module; the one natural sub-module is weight_idx_counter (load/increment/terminal-count flag).

Verification
REQ-032 RST, then START, W_READY=1 constant -> W_IDX 0..27 on 28 consecutive cycles starting 1 cycle after START, W_LAST with idx 27, DONE one cycle later.
REQ-033 FETCH with W_READY toggling 1,0,0,1 -> W_DATA/W_IDX held stable during stall, BRAM_EN=0 in stalled cycles, no word lost or duplicated.
REQ-034 LD_START then 28 words 0x0000..0x001B with LD_VALID gaps -> 28 writes addr=data, LD_DONE once; following START returns 0x0000..0x001B in order.
REQ-035 START and LD_START in same IDLE cycle -> LOAD entered, LD_READY=1, no read issued.
REQ-036 RST asserted at W_IDX=10 -> next cycle IDLE, W_VALID=0, BRAM_EN=0, no DONE; new START restarts at idx 0.
REQ-037 START pulsed during FETCH -> ignored; exactly 28 transfers and one DONE.

Source files
------------

// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared definitions for the weight BRAM controllers: controller state
// encoding and the default geometry of one neuron's weight memory.
package weight_fetch_ctrl_pkg;

    localparam int WF_DEPTH = 28;  // weight words per neuron BRAM
    localparam int WF_AW    = 5;   // BRAM address width
    localparam int WF_DW    = 16;  // weight word width

    // Binary-encoded controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } wf_state_e;

endpackage

// File: rtl/weight_fetch_ctrl_idx_counter.sv
// Weight index counter: synchronous clear, increment, terminal-count flag.
// The count saturates at DEPTH-1 so it never forms an address past the end.
module weight_idx_counter
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = WF_DEPTH,
    parameter int AW    = WF_AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_count,
    output logic          o_terminal
);

    logic [AW-1:0] r_count;
    logic          w_terminal;

    assign w_terminal = (r_count == AW'(DEPTH - 1));
    assign o_count    = r_count;
    assign o_terminal = w_terminal;

    // Count accesses; clear is used to guarantee a zero index at pass start
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: loads a neuron's weight BRAM from a valid/ready
// stream and streams the weights back out to the MAC with one-cycle read
// latency. W_DATA is taken straight from the BRAM output, so a stalled
// word is held by suppressing the next read rather than by a data register.
//
// Handshakes: a word moves on LD_DI when LD_VALID && LD_READY at a rising
// edge, and on W_DATA when W_VALID && W_READY at a rising edge. A producer
// keeps its valid and data stable until the transfer; the consumer may
// change ready freely.
module weight_fetch_ctrl
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = WF_DEPTH,
    parameter int AW    = WF_AW,
    parameter int DW    = WF_DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_ld_start,
    input  logic [DW-1:0] i_ld_di,
    input  logic          i_ld_valid,
    output logic          o_ld_ready,
    output logic [AW-1:0] o_bram_addr,
    output logic [DW-1:0] o_bram_di,
    output logic          o_bram_en,
    output logic          o_bram_we,
    input  logic [DW-1:0] i_bram_do,
    output logic [DW-1:0] o_w_data,
    output logic [AW-1:0] o_w_idx,
    output logic          o_w_valid,
    output logic          o_w_last,
    input  logic          i_w_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_ld_done,
    output logic [1:0]    o_dbg_state
);

    wf_state_e     r_state;
    wf_state_e     w_next;
    logic          r_w_valid;
    logic [AW-1:0] r_w_idx;
    logic          r_done;
    logic          r_ld_done;

    logic [AW-1:0] w_cnt;
    logic          w_term;
    logic          w_write;
    logic          w_issue;
    logic          w_xfer;

    assign w_xfer  = r_w_valid && i_w_ready;
    assign w_write = (r_state == ST_LOAD) && i_ld_valid;
    // A read may only be issued when the output slot is free or draining now
    assign w_issue = (r_state == ST_FETCH) && (w_cnt <= AW'(DEPTH - 1))
                     && (!r_w_valid || i_w_ready);

    weight_idx_counter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_idx_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (r_state == ST_IDLE),
        .i_inc      (w_write || w_issue),
        .o_count    (w_cnt),
        .o_terminal (w_term)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; load requests take priority over fetch requests
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_ld_start) begin
                    w_next = ST_LOAD;
                end else if (i_start) begin
                    w_next = ST_FETCH;
                end
            end
            ST_LOAD: begin
                if (w_write && w_term) begin
                    w_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (w_issue && w_term) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_xfer) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // BRAM port is driven only on an actual write or read issue
    always_comb begin
        o_bram_en   = w_write || w_issue;
        o_bram_we   = w_write;
        o_bram_addr = w_cnt;
        o_bram_di   = w_write ? i_ld_di : '0;
    end

    // Output word tracking: valid/index follow the issued read by one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_w_valid <= 1'b0;
            r_w_idx   <= '0;
        end else if (w_issue) begin
            r_w_valid <= 1'b1;
            r_w_idx   <= w_cnt;
        end else if (w_xfer) begin
            r_w_valid <= 1'b0;
        end
    end

    // Completion pulses land in the first IDLE cycle after the pass
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done    <= 1'b0;
            r_ld_done <= 1'b0;
        end else begin
            r_done    <= (r_state == ST_DRAIN) && w_xfer;
            r_ld_done <= w_write && w_term;
        end
    end

    assign o_ld_ready  = (r_state == ST_LOAD);
    assign o_w_data    = i_bram_do;
    assign o_w_idx     = r_w_idx;
    assign o_w_valid   = r_w_valid;
    assign o_w_last    = r_w_valid && (r_w_idx == AW'(DEPTH - 1));
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_ld_done   = r_ld_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Testbench for weight_fetch_ctrl: behavioural BRAM, load/fetch scenarios
// checked against a word-level model of the weight memory contents.
module tb_weight_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_ld_start = 1'b0;
    logic [DW-1:0] i_ld_di = '0;
    logic          i_ld_valid = 1'b0;
    logic          o_ld_ready;
    logic [AW-1:0] o_bram_addr;
    logic [DW-1:0] o_bram_di;
    logic          o_bram_en;
    logic          o_bram_we;
    logic [DW-1:0] i_bram_do = '0;
    logic [DW-1:0] o_w_data;
    logic [AW-1:0] o_w_idx;
    logic          o_w_valid;
    logic          o_w_last;
    logic          i_w_ready = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic          o_ld_done;
    logic [1:0]    o_dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] bram_mem [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    weight_fetch_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_ld_start  (i_ld_start),
        .i_ld_di     (i_ld_di),
        .i_ld_valid  (i_ld_valid),
        .o_ld_ready  (o_ld_ready),
        .o_bram_addr (o_bram_addr),
        .o_bram_di   (o_bram_di),
        .o_bram_en   (o_bram_en),
        .o_bram_we   (o_bram_we),
        .i_bram_do   (i_bram_do),
        .o_w_data    (o_w_data),
        .o_w_idx     (o_w_idx),
        .o_w_valid   (o_w_valid),
        .o_w_last    (o_w_last),
        .i_w_ready   (i_w_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ld_done   (o_ld_done),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    // behavioural BRAM: write on posedge, read data updates on negedge
    always @(posedge i_clk) begin
        if (o_bram_en && o_bram_we && o_bram_addr < DEPTH) bram_mem[o_bram_addr] <= o_bram_di;
    end
    always @(negedge i_clk) begin
        if (o_bram_en && !o_bram_we) i_bram_do <= (o_bram_addr < DEPTH) ? bram_mem[o_bram_addr] : 'x;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        #1;
        vectors++;
        if ({o_busy, o_w_valid, o_done, o_ld_done, o_ld_ready, o_bram_en, o_bram_we} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {o_busy, o_w_valid, o_done, o_ld_done, o_ld_ready, o_bram_en, o_bram_we});
        end
        vectors++;
        if (o_w_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_idx: got %0d expected 0", o_w_idx);
        end
        i_rst = 1'b0;
        tick();
    endtask

    // Load DEPTH words; gaps on LD_VALID; optionally START raised with LD_START
    task automatic run_load(input bit both, input bit seq_data);
        logic [DW-1:0] words [DEPTH];
        int k;
        int done_cyc;
        int ld_done_cnt;
        for (int i = 0; i < DEPTH; i++) words[i] = seq_data ? DW'(i) : DW'($urandom);
        k = 0;
        done_cyc = -1;
        ld_done_cnt = 0;
        i_ld_start = 1'b1;
        i_start = both;
        tick();
        i_ld_start = 1'b0;
        i_start = 1'b0;
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            i_ld_valid = (k < DEPTH) && !(both && cyc == 0) && ($urandom_range(0, 2) != 0);
            i_ld_di = (k < DEPTH) ? words[k] : DW'($urandom);
            #1;
            if (o_ld_done) begin
                ld_done_cnt++;
                done_cyc = cyc;
                vectors++;
                if (k != DEPTH) begin
                    miscompares++;
                    $display("FAIL ld_done_early: got %0d writes expected %0d", k, DEPTH);
                end
            end
            vectors++;
            if (o_ld_ready !== (k < DEPTH) || o_busy !== (k < DEPTH)) begin
                miscompares++;
                $display("FAIL ld_ready_busy: got %b%b expected %b", o_ld_ready, o_busy, k < DEPTH);
            end
            vectors++;
            if (o_bram_en !== i_ld_valid || o_bram_we !== i_ld_valid) begin
                miscompares++;
                $display("FAIL ld_bram_ctl: got en=%b we=%b expected %b", o_bram_en, o_bram_we, i_ld_valid);
            end
            if (i_ld_valid) begin
                vectors++;
                if (o_bram_addr !== AW'(k) || o_bram_di !== words[k]) begin
                    miscompares++;
                    $display("FAIL ld_write: got addr=%0d di=%0h expected addr=%0d di=%0h",
                             o_bram_addr, o_bram_di, k, words[k]);
                end
                model_mem[k] = words[k];
                k++;
            end
            tick();
        end
        i_ld_valid = 1'b0;
        vectors++;
        if (done_cyc < 0) begin
            miscompares++;
            $display("FAIL ld_timeout: got %0d writes expected %0d and LD_DONE", k, DEPTH);
        end
        for (int t = 0; t < 3; t++) begin
            #1;
            vectors++;
            if (o_ld_done || o_busy || o_w_valid || o_done) begin
                miscompares++;
                $display("FAIL ld_after: got ld_done=%b busy=%b w_valid=%b done=%b expected 0",
                         o_ld_done, o_busy, o_w_valid, o_done);
            end
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (bram_mem[i] !== model_mem[i]) begin
                miscompares++;
                $display("FAIL ld_content[%0d]: got %0h expected %0h", i, bram_mem[i], model_mem[i]);
            end
        end
    endtask

    // Fetch pass: mode 0 ready=1, mode 1 ready pattern 1,0,0,1, mode 2 random
    task automatic run_fetch(input int mode, input bit inject, input bit timing);
        int done_cyc;
        int first_x;
        int last_x;
        int nx;
        int n_done;
        bit stalled;
        logic [DW-1:0] held_d;
        logic [AW-1:0] held_i;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_mem[i]);
        done_cyc = -1;
        first_x = -1;
        last_x = -1;
        nx = 0;
        n_done = 0;
        stalled = 1'b0;
        held_d = '0;
        held_i = '0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            case (mode)
                0: i_w_ready = 1'b1;
                1: i_w_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: i_w_ready = 1'($urandom_range(0, 1));
            endcase
            i_start = inject && (cyc == 5);
            #1;
            if (o_bram_en) begin
                vectors++;
                if (o_bram_we !== 1'b0 || o_bram_addr > AW'(DEPTH - 1)) begin
                    miscompares++;
                    $display("FAIL fetch_issue: got we=%b addr=%0d expected read below %0d",
                             o_bram_we, o_bram_addr, DEPTH);
                end
            end
            if (o_w_valid && !i_w_ready) begin
                vectors++;
                if (o_bram_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_en: got %b expected 0", o_bram_en);
                end
            end
            if (stalled) begin
                vectors++;
                if (o_w_valid !== 1'b1 || o_w_idx !== held_i || o_w_data !== held_d) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b idx=%0d d=%0h expected v=1 idx=%0d d=%0h",
                             o_w_valid, o_w_idx, o_w_data, held_i, held_d);
                end
            end
            vectors++;
            if (o_w_last !== (o_w_valid && o_w_idx == AW'(DEPTH - 1))) begin
                miscompares++;
                $display("FAIL w_last: got %b expected %b", o_w_last, o_w_valid && o_w_idx == AW'(DEPTH - 1));
            end
            if (o_w_valid && i_w_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_word: got idx=%0d expected no transfer", o_w_idx);
                end else begin
                    if (o_w_idx !== AW'(DEPTH - exp_q.size()) || o_w_data !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL xfer: got idx=%0d d=%0h expected idx=%0d d=%0h",
                                 o_w_idx, o_w_data, DEPTH - exp_q.size(), exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                nx++;
            end
            vectors++;
            if (o_busy !== !o_done) begin
                miscompares++;
                $display("FAIL fetch_busy: got %b expected %b", o_busy, !o_done);
            end
            if (o_done) begin
                done_cyc = cyc;
                n_done++;
                vectors++;
                if (exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL done_early: got %0d words left expected 0", exp_q.size());
                end
            end
            stalled = o_w_valid && !i_w_ready;
            held_d = o_w_data;
            held_i = o_w_idx;
            tick();
        end
        i_start = 1'b0;
        vectors++;
        if (done_cyc < 0 || nx != DEPTH || n_done != 1) begin
            miscompares++;
            $display("FAIL fetch_count: got %0d transfers %0d done expected %0d transfers 1 done",
                     nx, n_done, DEPTH);
        end
        if (timing) begin
            vectors++;
            if (first_x != 1 || last_x != DEPTH || done_cyc != DEPTH + 1) begin
                miscompares++;
                $display("FAIL fetch_timing: got first=%0d last=%0d done=%0d expected 1 %0d %0d",
                         first_x, last_x, done_cyc, DEPTH, DEPTH + 1);
            end
        end
        i_w_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            vectors++;
            if (o_w_valid || o_busy || o_done || o_bram_en) begin
                miscompares++;
                $display("FAIL fetch_after: got v=%b busy=%b done=%b en=%b expected 0",
                         o_w_valid, o_busy, o_done, o_bram_en);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid_fetch();
        bit hit;
        hit = 1'b0;
        i_w_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            #1;
            if (o_w_valid && o_w_idx == AW'(10)) hit = 1'b1;
            else tick();
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rst_reach_idx10: got no idx 10 expected idx 10");
        end
        i_rst = 1'b1;
        tick();
        #1;
        vectors++;
        if ({o_busy, o_w_valid, o_bram_en, o_bram_we, o_done, o_ld_ready} !== 6'b0 || o_w_idx !== '0) begin
            miscompares++;
            $display("FAIL rst_abort: got busy=%b v=%b en=%b we=%b done=%b ldr=%b idx=%0d expected 0",
                     o_busy, o_w_valid, o_bram_en, o_bram_we, o_done, o_ld_ready, o_w_idx);
        end
        i_rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            #1;
            vectors++;
            if (o_done || o_w_valid || o_busy) begin
                miscompares++;
                $display("FAIL rst_after: got done=%b v=%b busy=%b expected 0", o_done, o_w_valid, o_busy);
            end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bram_mem[i] = DW'($urandom);
            model_mem[i] = bram_mem[i];
        end
        test_reset();
        run_fetch(0, 1'b0, 1'b1);   // preloaded random contents, full-rate
        run_load(1'b0, 1'b1);       // words 0x0000..0x001B with gaps
        run_fetch(0, 1'b0, 1'b1);   // back-to-back readback timing
        run_fetch(1, 1'b0, 1'b0);   // ready 1,0,0,1 stalls
        run_load(1'b1, 1'b0);       // START and LD_START together, random words
        run_fetch(2, 1'b0, 1'b0);   // random ready
        run_fetch(2, 1'b1, 1'b0);   // START pulsed mid-fetch
        test_rst_mid_fetch();
        run_fetch(0, 1'b0, 1'b1);   // restart from idx 0 after abort
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
